pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the width of the datapath payload (PC, ALU result, store data).
REQ-002 The block SHALL have parameter CTRL_W, default 8, giving the width of control bits (reg_write, mem_write, mem_width, ...) that are forced to zero in bubbles.
REQ-003 The block SHALL have parameter SKID, default 0: 0 = single register; 1 = register plus one-entry skid buffer.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous flush; squashes all held entries.
REQ-007 in_valid  input  1  upstream stage presents a valid entry.
REQ-008 in_ready  output  1  block accepts the upstream entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 in_ctrl  input  CTRL_W  upstream control bits.
REQ-011 out_valid  output  1  output entry is valid.
REQ-012 out_ready  input  1  downstream stage consumes the output entry this cycle.
REQ-013 out_data  output  DATA_W  registered payload.
REQ-014 out_ctrl  output  CTRL_W  registered control bits; zero whenever out_valid=0.
REQ-015 occupancy  output  2  number of held valid entries (0..1 for SKID=0, 0..2 for SKID=1).

Function
REQ-016 Input fire SHALL be defined as in_valid & in_ready, and output fire as out_valid & out_ready.
REQ-017 All outputs SHALL be driven from registers, except in_ready when SKID=0 and the ctrl bubble gating of REQ-019.
REQ-018 Latency SHALL be one cycle: an entry accepted at edge N appears on out_* after edge N when the stage was empty or draining.
REQ-019 out_ctrl SHALL equal the held ctrl AND-ed with out_valid, so a bubble never asserts any control bit.
REQ-020 SKID=0: in_ready SHALL equal (!out_valid | out_ready) & !flush & rst_n.
REQ-021 SKID=0: on input fire, the main register SHALL load in_data/in_ctrl and set valid; on output fire without input fire, valid SHALL clear.
REQ-022 SKID=1: in_ready SHALL equal !skid_valid & !flush & rst_n, with skid_valid a register, so in_ready has no combinational path from out_ready.
REQ-023 SKID=1: on input fire while the main register is empty or firing, the main register SHALL load the input.
REQ-024 SKID=1: on input fire while the main register is valid and not firing, the skid register SHALL load the input.
REQ-025 SKID=1: on output fire with skid valid, the main register SHALL load the skid entry and skid_valid SHALL clear, in the same cycle.
REQ-026 Ordering SHALL be strict FIFO; no entry is dropped or duplicated except by flush.
REQ-027 flush SHALL take priority over every same-cycle event: on the next edge all valids clear, held ctrl clears, held data is retained, and an in_valid presented during flush is not accepted.
REQ-028 A simultaneous input fire and output fire with occupancy 1 SHALL keep occupancy at 1 and replace the entry.
REQ-029 occupancy SHALL be main_valid + skid_valid.

Reset
REQ-030 While rst_n=0, asynchronously, all valids, held data and held ctrl SHALL be 0, and out_valid, out_ctrl, out_data, occupancy and in_ready SHALL be 0.
REQ-031 At the first edge after rst_n rises with flush=0, in_ready SHALL be 1 in both modes.
REQ-032 Reset asserted mid-transfer SHALL discard all held entries without waiting for a clock edge.

Verification
REQ-033 SKID=0: in_valid=1, out_ready=1 held, data 1,2,3 on consecutive cycles -> out_data 1,2,3 one cycle later, out_valid=1 throughout, occupancy=1.
REQ-034 SKID=1: accept 0xA, then out_ready=0 and send 0xB -> occupancy=2, in_ready=0, out_data=0xA; raise out_ready -> 0xA then 0xB, no loss.
REQ-035 Bubble: in_ctrl=0xFF with in_valid=0 -> out_valid=0 and out_ctrl=0x00 on every cycle.
REQ-036 flush in the same cycle as in_valid=1 with occupancy 2 -> next cycle occupancy=0, out_valid=0, out_ctrl=0; the new entry never appears at the output.
REQ-037 rst_n dropped between edges while occupancy=1 -> out_valid=0 and out_data=0 immediately; after release, in_ready=1.
REQ-038 Random valid/ready stress with a scoreboard, DATA_W=64 and CTRL_W=3, both SKID values -> in-order, lossless, occupancy never above 1+SKID.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: upstream/downstream valid-ready bundle of a pipeline stage register.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [1:0]        occupancy;

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, occupancy
    );
    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: one-cycle pipeline register with bubble-safe ctrl, flush and optional skid entry.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int SKID   = 0
) (
    input logic             clk,
    input logic             rst_n,
    input logic             flush,
    pipe_stage_reg_if.slave bus
);
    logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
    logic              in_fire, out_fire;

    // With a skid entry, in_ready looks only at registered state, cutting the out_ready path
    assign bus.in_ready  = (SKID != 0 ? !skid_valid_q : (!main_valid_q | bus.out_ready)) & !flush & rst_n;
    assign in_fire       = bus.in_valid & bus.in_ready;
    assign out_fire      = main_valid_q & bus.out_ready;
    assign bus.out_valid = main_valid_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_ctrl  = main_ctrl_q & {CTRL_W{main_valid_q}};
    assign bus.occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_ctrl_d  = main_ctrl_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_ctrl_d  = skid_ctrl_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_ctrl_d  = '0;
            skid_valid_d = 1'b0;
            skid_ctrl_d  = '0;
        end else begin
            if (out_fire) begin
                main_valid_d = skid_valid_q;
                main_data_d  = skid_valid_q ? skid_data_q : main_data_q;
                main_ctrl_d  = skid_valid_q ? skid_ctrl_q : main_ctrl_q;
                skid_valid_d = 1'b0;
            end
            // in_fire implies the skid slot is empty, so it never collides with the refill above
            if (in_fire && (!main_valid_q || out_fire)) begin
                main_valid_d = 1'b1;
                main_data_d  = bus.in_data;
                main_ctrl_d  = bus.in_ctrl;
            end else if (in_fire && SKID != 0) begin
                skid_valid_d = 1'b1;
                skid_data_d  = bus.in_data;
                skid_ctrl_d  = bus.in_ctrl;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_ctrl_q  <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_ctrl_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_ctrl_q  <= main_ctrl_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_ctrl_q  <= skid_ctrl_d;
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: scoreboard bench for both SKID modes at DATA_W=64, CTRL_W=3.
module tb_pipe_stage_reg;
    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    int   n_vec = 0;
    int   n_bad = 0;
    logic [66:0] q0[$];
    logic [66:0] q1[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(3)) b0 ();
    pipe_stage_reg_if #(.DATA_W(64), .CTRL_W(3)) b1 ();

    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .SKID(0)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b0));
    pipe_stage_reg #(.DATA_W(64), .CTRL_W(3), .SKID(1)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b1));

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic score(input int id, input logic [66:0] act);
        logic [66:0] exp;
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL s%0d out: got %h, expected no entry", id, act);
        end else begin
            if (id == 0) exp = q0.pop_front();
            else exp = q1.pop_front();
            check($sformatf("s%0d out", id), act, exp);
        end
    endtask

    // Monitor: record accepted inputs, score consumed outputs, watch invariants
    always @(negedge clk) begin
        if (rst_n) begin
            if (b0.in_valid && b0.in_ready) q0.push_back({b0.in_ctrl, b0.in_data});
            if (b1.in_valid && b1.in_ready) q1.push_back({b1.in_ctrl, b1.in_data});
            if (!flush && b0.out_valid && b0.out_ready) score(0, {b0.out_ctrl, b0.out_data});
            if (!flush && b1.out_valid && b1.out_ready) score(1, {b1.out_ctrl, b1.out_data});
            check("s0 occ bound", 67'(b0.occupancy > 2'd1), 67'd0);
            check("s1 occ bound", 67'(b1.occupancy > 2'd2), 67'd0);
            if (!b0.out_valid) check("s0 bubble ctrl", 67'(b0.out_ctrl), 67'd0);
            if (!b1.out_valid) check("s1 bubble ctrl", 67'(b1.out_ctrl), 67'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        b0.in_valid = 1'b0; b0.in_data = '0; b0.in_ctrl = '0; b0.out_ready = 1'b0;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_ctrl = '0; b1.out_ready = 1'b0;
        #2;
        check("rst s0 out_valid", 67'(b0.out_valid), 67'd0);
        check("rst s0 out_data", 67'(b0.out_data), 67'd0);
        check("rst s0 in_ready", 67'(b0.in_ready), 67'd0);
        check("rst s1 occupancy", 67'(b1.occupancy), 67'd0);
        check("rst s1 in_ready", 67'(b1.in_ready), 67'd0);
        #10 rst_n = 1'b1;
        step();
        check("post-rst s0 in_ready", 67'(b0.in_ready), 67'd1);
        check("post-rst s1 in_ready", 67'(b1.in_ready), 67'd1);

        // SKID=0 streaming 1,2,3 with out_ready held high
        b0.out_ready = 1'b1;
        b0.in_valid = 1'b1; b0.in_ctrl = 3'd5;
        for (int i = 1; i <= 3; i++) begin
            b0.in_data = 64'(i);
            step();
            check("s0 stream data", 67'(b0.out_data), 67'(i));
            check("s0 stream valid", 67'(b0.out_valid), 67'd1);
            check("s0 stream occ", 67'(b0.occupancy), 67'd1);
        end
        b0.in_valid = 1'b0;
        step();
        check("s0 drained valid", 67'(b0.out_valid), 67'd0);
        b0.out_ready = 1'b0;

        // SKID=1: A held, B goes to skid, then both drain in order
        b1.in_valid = 1'b1; b1.in_ctrl = 3'd3; b1.in_data = 64'hA;
        step();
        check("s1 A occ", 67'(b1.occupancy), 67'd1);
        b1.in_data = 64'hB;
        step();
        check("s1 AB occ", 67'(b1.occupancy), 67'd2);
        check("s1 AB in_ready", 67'(b1.in_ready), 67'd0);
        check("s1 AB out_data", 67'(b1.out_data), 67'hA);
        b1.in_valid = 1'b0; b1.out_ready = 1'b1;
        step();
        check("s1 B head", 67'(b1.out_data), 67'hB);
        check("s1 B occ", 67'(b1.occupancy), 67'd1);
        check("s1 B in_ready", 67'(b1.in_ready), 67'd1);
        step();
        check("s1 empty valid", 67'(b1.out_valid), 67'd0);

        // SKID=1 replace at occupancy 1 with simultaneous in/out fire
        b1.in_valid = 1'b1; b1.in_ctrl = 3'd6;
        for (int i = 0; i < 3; i++) begin
            b1.in_data = 64'h11 + 64'(i);
            step();
            check("s1 replace data", 67'(b1.out_data), 67'h11 + 67'(i));
            check("s1 replace occ", 67'(b1.occupancy), 67'd1);
        end
        b1.in_valid = 1'b0;
        step();
        b1.out_ready = 1'b0;

        // Bubbles with every ctrl bit set
        b0.in_ctrl = '1; b1.in_ctrl = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("bubble s0 ctrl", 67'(b0.out_ctrl), 67'd0);
            check("bubble s1 ctrl", 67'(b1.out_ctrl), 67'd0);
            check("bubble s1 valid", 67'(b1.out_valid), 67'd0);
        end

        // Flush with SKID=1 full and a new entry offered
        b1.in_valid = 1'b1; b1.in_ctrl = 3'd7; b1.in_data = 64'h21;
        step();
        b1.in_data = 64'h22;
        step();
        check("s1 pre-flush occ", 67'(b1.occupancy), 67'd2);
        b1.in_data = 64'h23;
        b0.in_valid = 1'b1; b0.in_data = 64'h99;
        q0.delete(); q1.delete();
        flush = 1'b1;
        #1;
        check("flush s0 in_ready", 67'(b0.in_ready), 67'd0);
        step();
        flush = 1'b0; b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        check("flush s1 occ", 67'(b1.occupancy), 67'd0);
        check("flush s1 valid", 67'(b1.out_valid), 67'd0);
        check("flush s1 ctrl", 67'(b1.out_ctrl), 67'd0);
        check("flush s1 data kept", 67'(b1.out_data), 67'h21);
        check("flush s0 valid", 67'(b0.out_valid), 67'd0);
        step();
        check("flush s1 no 0x23", 67'(b1.out_valid), 67'd0);

        // Asynchronous reset mid-transfer
        b0.in_valid = 1'b1; b0.in_data = 64'h31; b0.in_ctrl = 3'd1;
        b1.in_valid = 1'b1; b1.in_data = 64'h32; b1.in_ctrl = 3'd2;
        step();
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        check("s0 held occ", 67'(b0.occupancy), 67'd1);
        check("s0 stalled in_ready", 67'(b0.in_ready), 67'd0);
        #2;
        q0.delete(); q1.delete();
        rst_n = 1'b0;
        #1;
        check("async rst s0 valid", 67'(b0.out_valid), 67'd0);
        check("async rst s0 data", 67'(b0.out_data), 67'd0);
        check("async rst s1 occ", 67'(b1.occupancy), 67'd0);
        check("async rst s1 data", 67'(b1.out_data), 67'd0);
        #3 rst_n = 1'b1;
        step();
        check("rerst s0 in_ready", 67'(b0.in_ready), 67'd1);
        check("rerst s1 in_ready", 67'(b1.in_ready), 67'd1);

        // Random valid/ready stress on both stages
        for (int i = 0; i < 500; i++) begin
            b0.in_valid = 1'($urandom_range(0, 1)); b0.in_data = {$urandom, $urandom};
            b0.in_ctrl = 3'($urandom); b0.out_ready = 1'($urandom_range(0, 1));
            b1.in_valid = 1'($urandom_range(0, 1)); b1.in_data = {$urandom, $urandom};
            b1.in_ctrl = 3'($urandom); b1.out_ready = 1'($urandom_range(0, 1));
            step();
        end
        b0.in_valid = 1'b0; b1.in_valid = 1'b0;
        b0.out_ready = 1'b1; b1.out_ready = 1'b1;
        repeat (5) step();
        check("s0 lossless", 67'(q0.size()), 67'd0);
        check("s1 lossless", 67'(q1.size()), 67'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
